// File: rtl/freq_counter_multi.sv
// -----------------------------------------------------------------------------
// freq_counter_multi
//
// Multi-channel frequency counter. It counts rising edges on NUM_CH slow
// asynchronous inputs over a gate window of gate_cycles_i clk cycles. Each
// input goes through a SYNC_STAGES-flop synchroniser and a registered
// rising-edge detector. A start request seeds the window. One-shot mode
// returns to IDLE after one window. Continuous mode reloads the window with no
// gap and no lost edges. Each result is latched into count_o/overflow_o and
// announced with a one-cycle done_o pulse.
//
// Optional feature: define FREQCNT_MINMAX_EN to add per-channel running
// minimum/maximum of the latched counts (min_o/max_o, cleared by minmax_clr_i).
//
// Ports:
//   clk               system clock
//   reset_n           asynchronous active-low reset
//   sig_i             NUM_CH asynchronous signals to measure
//   gate_cycles_i     window length in clk cycles, sampled on accepted start
//   mode_continuous_i 1 = back-to-back windows, 0 = one-shot (sampled on start)
//   start_i           start request, level-sampled in IDLE
//   stop_i            abort request (wins over start_i)
//   busy_o            window in progress
//   done_o            one-cycle pulse when count_o/overflow_o update
//   count_o           latched counts, channel n at [n*CNT_WIDTH +: CNT_WIDTH]
//   overflow_o        latched per-channel saturation flag
//   cfg_err_o         sticky: start attempted with gate_cycles_i == 0
//   minmax_clr_i      (FREQCNT_MINMAX_EN) reset min_o to all-ones, max_o to 0
//   min_o, max_o      (FREQCNT_MINMAX_EN) running min/max of latched counts
// -----------------------------------------------------------------------------
module freq_counter_multi #(
    parameter int NUM_CH      = 2,
    parameter int CNT_WIDTH   = 32,
    parameter int GATE_WIDTH  = 26,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_CH-1:0]           sig_i,
    input  logic [GATE_WIDTH-1:0]       gate_cycles_i,
    input  logic                        mode_continuous_i,
    input  logic                        start_i,
    input  logic                        stop_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [NUM_CH*CNT_WIDTH-1:0] count_o,
    output logic [NUM_CH-1:0]           overflow_o,
    output logic                        cfg_err_o
`ifdef FREQCNT_MINMAX_EN
    ,
    input  logic                        minmax_clr_i,
    output logic [NUM_CH*CNT_WIDTH-1:0] min_o,
    output logic [NUM_CH*CNT_WIDTH-1:0] max_o
`endif
);

    typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_e;
    typedef logic [NUM_CH-1:0][CNT_WIDTH-1:0] cnt_vec_t;

    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
    localparam logic [GATE_WIDTH-1:0] GATE_ONE = GATE_WIDTH'(1);

    state_e                              state_q, state_d;
    logic [SYNC_STAGES-1:0][NUM_CH-1:0]  sync_q, sync_d;
    logic [NUM_CH-1:0]                   prev_q, prev_d;
    logic [NUM_CH-1:0]                   edge_q, edge_d;
    logic [GATE_WIDTH-1:0]               timer_q, timer_d;
    logic [GATE_WIDTH-1:0]               gate_q, gate_d;
    logic                                cont_q, cont_d;
    cnt_vec_t                            cnt_q, cnt_d;
    logic [NUM_CH-1:0]                   win_ovf_q, win_ovf_d;
    cnt_vec_t                            count_q, count_d;
    logic [NUM_CH-1:0]                   overflow_q, overflow_d;
    logic                                done_q, done_d;
    logic                                cfg_err_q, cfg_err_d;

    cnt_vec_t                            sum_cnt;   // counter + this cycle's edge, saturating
    logic [NUM_CH-1:0]                   sum_ovf;   // window flag including this cycle
    logic                                win_end;   // terminal cycle: results latch now

    // Synchroniser shifts toward the MSB; the edge detector is registered, so
    // a pin transition is seen by the counters SYNC_STAGES+1 cycles later.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_i};
        prev_d = sync_q[SYNC_STAGES-1];
        edge_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path through the
        // case/if tree leaves one unassigned, which would infer a latch.
        state_d    = state_q;
        timer_d    = timer_q;
        gate_d     = gate_q;
        cont_d     = cont_q;
        cnt_d      = cnt_q;
        win_ovf_d  = win_ovf_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        cfg_err_d  = cfg_err_q;
        win_end    = 1'b0;
        sum_cnt    = cnt_q;
        sum_ovf    = win_ovf_q;

        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (edge_q[ch]) begin
                if (cnt_q[ch] == CNT_MAX) sum_ovf[ch] = 1'b1;
                else                      sum_cnt[ch] = cnt_q[ch] + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start_i && !stop_i) begin
                    if (gate_cycles_i == '0) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        timer_d   = gate_cycles_i;
                        gate_d    = gate_cycles_i;
                        cont_d    = mode_continuous_i;
                        cnt_d     = '0;
                        win_ovf_d = '0;
                        cfg_err_d = 1'b0;
                        state_d   = COUNT;
                    end
                end
            end
            COUNT: begin
                cnt_d     = sum_cnt;
                win_ovf_d = sum_ovf;
                timer_d   = timer_q - GATE_ONE;
                if (timer_q == GATE_ONE) begin
                    win_end    = 1'b1;
                    count_d    = sum_cnt;
                    overflow_d = sum_ovf;
                    done_d     = 1'b1;
                    // Reload in the terminal cycle so the next window starts
                    // on the very next cycle with no gap.
                    if (cont_q && !stop_i) begin
                        cnt_d     = '0;
                        win_ovf_d = '0;
                        timer_d   = gate_q;
                    end else begin
                        state_d   = IDLE;
                    end
                end else if (stop_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            prev_q     <= '0;
            edge_q     <= '0;
            timer_q    <= '0;
            gate_q     <= '0;
            cont_q     <= 1'b0;
            cnt_q      <= '0;
            win_ovf_q  <= '0;
            count_q    <= '0;
            overflow_q <= '0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            edge_q     <= edge_d;
            timer_q    <= timer_d;
            gate_q     <= gate_d;
            cont_q     <= cont_d;
            cnt_q      <= cnt_d;
            win_ovf_q  <= win_ovf_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign busy_o     = (state_q == COUNT);
    assign done_o     = done_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign cfg_err_o  = cfg_err_q;

`ifdef FREQCNT_MINMAX_EN
    cnt_vec_t min_q, min_d, max_q, max_d;

    // Clear is applied first, then a coincident latched sample folds in.
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (minmax_clr_i) begin
                min_d[ch] = CNT_MAX;
                max_d[ch] = '0;
            end
            if (win_end) begin
                if (sum_cnt[ch] < min_d[ch]) min_d[ch] = sum_cnt[ch];
                if (sum_cnt[ch] > max_d[ch]) max_d[ch] = sum_cnt[ch];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign min_o = min_q;
    assign max_o = max_q;
`endif

endmodule

// File: tb/tb_freq_counter_multi.sv
// -----------------------------------------------------------------------------
// tb_freq_counter_multi
//
// Directed bench for freq_counter_multi. Two instances share all inputs: a
// default-width one (dut) and a CNT_WIDTH=4 one (dut_s) for saturation.
// Periodic test signals are generated per channel; any G consecutive cycles of
// a period-P square wave hold exactly G/P rising edges when P divides G.
// -----------------------------------------------------------------------------
module tb_freq_counter_multi;

    localparam int NUM_CH = 2;
    localparam int CW     = 32;
    localparam int CWS    = 4;
    localparam int GW     = 26;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic [NUM_CH-1:0]      sig;
    logic [GW-1:0]          gate;
    logic                   mode;
    logic                   start;
    logic                   stop;
    logic                   minmax_clr;

    logic                   busy, done, cfg_err;
    logic [NUM_CH*CW-1:0]   count;
    logic [NUM_CH-1:0]      overflow;
    logic                   busy_s, done_s, cfg_err_s;
    logic [NUM_CH*CWS-1:0]  count_s;
    logic [NUM_CH-1:0]      overflow_s;
`ifdef FREQCNT_MINMAX_EN
    logic [NUM_CH*CW-1:0]   min_v, max_v;
    logic [NUM_CH*CWS-1:0]  min_s, max_s;
`endif

    int checks   = 0;
    int failures = 0;
    int per [NUM_CH] = '{0, 0};

    freq_counter_multi #(.NUM_CH(NUM_CH), .CNT_WIDTH(CW), .GATE_WIDTH(GW), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .sig_i(sig), .gate_cycles_i(gate),
        .mode_continuous_i(mode), .start_i(start), .stop_i(stop),
        .busy_o(busy), .done_o(done), .count_o(count), .overflow_o(overflow),
        .cfg_err_o(cfg_err)
`ifdef FREQCNT_MINMAX_EN
        , .minmax_clr_i(minmax_clr), .min_o(min_v), .max_o(max_v)
`endif
    );

    freq_counter_multi #(.NUM_CH(NUM_CH), .CNT_WIDTH(CWS), .GATE_WIDTH(GW), .SYNC_STAGES(2)) dut_s (
        .clk(clk), .reset_n(reset_n), .sig_i(sig), .gate_cycles_i(gate),
        .mode_continuous_i(mode), .start_i(start), .stop_i(stop),
        .busy_o(busy_s), .done_o(done_s), .count_o(count_s), .overflow_o(overflow_s),
        .cfg_err_o(cfg_err_s)
`ifdef FREQCNT_MINMAX_EN
        , .minmax_clr_i(minmax_clr), .min_o(min_s), .max_o(max_s)
`endif
    );

    initial forever #5 clk = ~clk;

    // Square-wave generator: high for per/2 cycles, low for the rest; phase
    // restarts whenever the period changes. per == 0 holds the channel low.
    initial begin
        int ph [NUM_CH];
        int per_prev [NUM_CH];
        sig = '0;
        for (int c = 0; c < NUM_CH; c++) begin ph[c] = 0; per_prev[c] = 0; end
        forever begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                if (per[c] != per_prev[c]) begin ph[c] = 0; per_prev[c] = per[c]; end
                if (per[c] == 0) begin
                    sig[c] = 1'b0;
                end else begin
                    sig[c] = (ph[c] < per[c] / 2);
                    ph[c]  = (ph[c] + 1) % per[c];
                end
            end
        end
    end

    // One clock: returns at the falling edge after the next rising edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start(input int g, input logic m);
        gate  = GW'(g);
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Cycles until done is seen, or -1 if it never comes within the bound.
    task automatic wait_done(output int n);
        n = -1;
        for (int k = 1; k <= 1000; k++) begin
            tick();
            if (done) begin n = k; break; end
        end
    endtask

    task automatic test_reset();
        checks++; if (busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0) begin failures++;
            $display("FAIL reset_flags got busy=%b done=%b cfg_err=%b exp 0/0/0", busy, done, cfg_err); end
        checks++; if (count !== '0 || overflow !== '0) begin failures++;
            $display("FAIL reset_count got count=%h ovf=%b exp 0", count, overflow); end
`ifdef FREQCNT_MINMAX_EN
        checks++; if (min_v !== '1 || max_v !== '0) begin failures++;
            $display("FAIL reset_minmax got min=%h max=%h exp all-ones/0", min_v, max_v); end
`endif
        reset_n = 1'b1;
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin failures++;
            $display("FAIL reset_idle got busy=%b exp 0", busy); end
    endtask

    task automatic test_oneshot();
        int n, extra;
        per[0] = 4; per[1] = 10;
        repeat (20) tick();
        do_start(100, 1'b0);
        checks++; if (busy !== 1'b1) begin failures++;
            $display("FAIL os_busy got %b exp 1", busy); end
        wait_done(n);
        checks++; if (n != 100) begin failures++;
            $display("FAIL os_latency got %0d exp 100", n); end
        checks++; if (count[0 +: CW] !== 32'd25 || count[CW +: CW] !== 32'd10) begin failures++;
            $display("FAIL os_count got c0=%0d c1=%0d exp 25/10", count[0 +: CW], count[CW +: CW]); end
        checks++; if (overflow !== 2'b00 || busy !== 1'b0) begin failures++;
            $display("FAIL os_ovf_busy got ovf=%b busy=%b exp 00/0", overflow, busy); end
        checks++; if (count_s[0 +: CWS] !== 4'd15 || count_s[CWS +: CWS] !== 4'd10 || overflow_s !== 2'b01) begin failures++;
            $display("FAIL os_small got c0=%0d c1=%0d ovf=%b exp 15/10/01", count_s[0 +: CWS], count_s[CWS +: CWS], overflow_s); end
        extra = 0;
        for (int k = 0; k < 20; k++) begin tick(); if (done || busy) extra++; end
        checks++; if (extra != 0) begin failures++;
            $display("FAIL os_single_done got %0d extra busy/done cycles exp 0", extra); end
    endtask

    task automatic test_saturate();
        int n;
        per[0] = 8; per[1] = 0;
        repeat (20) tick();
        do_start(200, 1'b0);
        wait_done(n);
        checks++; if (n != 200) begin failures++;
            $display("FAIL sat_latency got %0d exp 200", n); end
        checks++; if (count[0 +: CW] !== 32'd25 || count[CW +: CW] !== 32'd0) begin failures++;
            $display("FAIL sat_wide got c0=%0d c1=%0d exp 25/0", count[0 +: CW], count[CW +: CW]); end
        checks++; if (count_s[0 +: CWS] !== 4'd15 || count_s[CWS +: CWS] !== 4'd0 || overflow_s !== 2'b01) begin failures++;
            $display("FAIL sat_small got c0=%0d c1=%0d ovf=%b exp 15/0/01", count_s[0 +: CWS], count_s[CWS +: CWS], overflow_s); end
        checks++; if (done_s !== 1'b1) begin failures++;
            $display("FAIL sat_small_done got %b exp 1", done_s); end
    endtask

    task automatic test_continuous();
        int n, total;
        per[0] = 5; per[1] = 0;
        repeat (20) tick();
        total = 0;
        do_start(50, 1'b1);
        for (int w = 0; w < 3; w++) begin
            wait_done(n);
            checks++; if (n != 50 || count[0 +: CW] !== 32'd10 || busy !== 1'b1) begin failures++;
                $display("FAIL cont_win%0d got gap=%0d c0=%0d busy=%b exp 50/10/1", w, n, count[0 +: CW], busy); end
            total += int'(count[0 +: CW]);
        end
        checks++; if (total != 30) begin failures++;
            $display("FAIL cont_total got %0d exp 30", total); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++;
            $display("FAIL cont_stop got busy=%b done=%b exp 0/0", busy, done); end
    endtask

    task automatic test_stop();
        int n, extra;
        per[0] = 5; per[1] = 0;
        repeat (20) tick();
        do_start(35, 1'b0);
        wait_done(n);
        checks++; if (count[0 +: CW] !== 32'd7) begin failures++;
            $display("FAIL stop_prior got %0d exp 7", count[0 +: CW]); end
        do_start(100, 1'b0);
        repeat (29) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++;
            $display("FAIL stop_mid got busy=%b done=%b exp 0/0", busy, done); end
        extra = 0;
        for (int k = 0; k < 150; k++) begin tick(); if (done) extra++; end
        checks++; if (extra != 0 || count[0 +: CW] !== 32'd7) begin failures++;
            $display("FAIL stop_hold got done_cnt=%0d c0=%0d exp 0/7", extra, count[0 +: CW]); end
        do_start(10, 1'b0);
        repeat (9) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || count[0 +: CW] !== 32'd2) begin failures++;
            $display("FAIL stop_term got done=%b busy=%b c0=%0d exp 1/0/2", done, busy, count[0 +: CW]); end
    endtask

    task automatic test_cfg_err();
        int n;
        gate = '0; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        checks++; if (cfg_err !== 1'b0 || busy !== 1'b0) begin failures++;
            $display("FAIL cfg_stop_wins got cfg_err=%b busy=%b exp 0/0", cfg_err, busy); end
        do_start(0, 1'b0);
        checks++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin failures++;
            $display("FAIL cfg_zero got cfg_err=%b busy=%b exp 1/0", cfg_err, busy); end
        repeat (3) tick();
        checks++; if (cfg_err !== 1'b1) begin failures++;
            $display("FAIL cfg_sticky got %b exp 1", cfg_err); end
        do_start(10, 1'b0);
        checks++; if (cfg_err !== 1'b0 || busy !== 1'b1) begin failures++;
            $display("FAIL cfg_clear got cfg_err=%b busy=%b exp 0/1", cfg_err, busy); end
        // A start while busy, with a different gate, must be ignored.
        gate = GW'(3); start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        checks++; if (n + 1 != 10) begin failures++;
            $display("FAIL cfg_latency got %0d exp 10", n + 1); end
    endtask

`ifdef FREQCNT_MINMAX_EN
    task automatic test_minmax();
        int n;
        per[0] = 5; per[1] = 0;
        minmax_clr = 1'b1;
        tick();
        minmax_clr = 1'b0;
        repeat (20) tick();
        do_start(50, 1'b0); wait_done(n);
        do_start(20, 1'b0); wait_done(n);
        checks++; if (count[0 +: CW] !== 32'd4) begin failures++;
            $display("FAIL mm_win2 got %0d exp 4", count[0 +: CW]); end
        do_start(35, 1'b0); wait_done(n);
        checks++; if (min_v[0 +: CW] !== 32'd4 || max_v[0 +: CW] !== 32'd10 || min_v[CW +: CW] !== 32'd0) begin failures++;
            $display("FAIL mm_vals got min0=%0d max0=%0d min1=%0d exp 4/10/0", min_v[0 +: CW], max_v[0 +: CW], min_v[CW +: CW]); end
        minmax_clr = 1'b1;
        tick();
        minmax_clr = 1'b0;
        checks++; if (min_v[0 +: CW] !== 32'hFFFF_FFFF || max_v[0 +: CW] !== 32'd0) begin failures++;
            $display("FAIL mm_clr got min0=%h max0=%0d exp ffffffff/0", min_v[0 +: CW], max_v[0 +: CW]); end
        do_start(50, 1'b0); wait_done(n);
        do_start(10, 1'b0);
        repeat (9) tick();
        minmax_clr = 1'b1;
        tick();
        minmax_clr = 1'b0;
        checks++; if (done !== 1'b1 || min_v[0 +: CW] !== 32'd2 || max_v[0 +: CW] !== 32'd2) begin failures++;
            $display("FAIL mm_clr_latch got done=%b min0=%0d max0=%0d exp 1/2/2", done, min_v[0 +: CW], max_v[0 +: CW]); end
    endtask
`endif

    task automatic test_async_reset();
        per[0] = 5; per[1] = 0;
        repeat (20) tick();
        do_start(100, 1'b0);
        repeat (20) tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0 || count !== '0 || overflow !== '0) begin failures++;
            $display("FAIL areset_main got busy=%b done=%b cfg=%b count=%h ovf=%b exp all 0", busy, done, cfg_err, count, overflow); end
        checks++; if (busy_s !== 1'b0 || count_s !== '0 || overflow_s !== '0) begin failures++;
            $display("FAIL areset_small got busy=%b count=%h ovf=%b exp all 0", busy_s, count_s, overflow_s); end
`ifdef FREQCNT_MINMAX_EN
        checks++; if (min_v !== '1 || max_v !== '0) begin failures++;
            $display("FAIL areset_minmax got min=%h max=%h exp all-ones/0", min_v, max_v); end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++;
            $display("FAIL areset_after got busy=%b done=%b exp 0/0", busy, done); end
    endtask

    initial begin
        start = 1'b0; stop = 1'b0; gate = '0; mode = 1'b0; minmax_clr = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_oneshot();
        test_saturate();
        test_continuous();
        test_stop();
        test_cfg_err();
`ifdef FREQCNT_MINMAX_EN
        test_minmax();
`endif
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
